// File: rtl/temp_seq_pkg.sv
// Shared definitions for the temperature micro-sequencer: widths, opcodes,
// instruction field positions, FSM state and pulse encodings.
package temp_seq_pkg;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_W   = 4;
    localparam int unsigned INSTR_W = OP_W + IMM_W;
    localparam int unsigned OP_LSB  = 4;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LOAD = 4'h1;
    localparam logic [OP_W-1:0] OP_INC  = 4'h2;
    localparam logic [OP_W-1:0] OP_DEC  = 4'h3;
    localparam logic [OP_W-1:0] OP_BRZ  = 4'h4;
    localparam logic [OP_W-1:0] OP_BRP  = 4'h5;
    localparam logic [OP_W-1:0] OP_BRN  = 4'h6;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h7;
    localparam logic [OP_W-1:0] OP_WAIT = 4'h8;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SETTLE = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PULSE_NONE = 2'd0,
        PULSE_LOAD = 2'd1,
        PULSE_INC  = 2'd2,
        PULSE_DEC  = 2'd3
    } pulse_e;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/temp_seq_decode.sv
// Combinational instruction decoder: selects the control pulse, forms the
// load value and resolves conditional branches against the register flags.
module temp_seq_decode
    import temp_seq_pkg::*;
(
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic              i_negative,
    input  logic              i_positive,
    input  logic              i_zero,
    output pulse_e            o_pulse,
    output logic [DATA_W-1:0] o_data,
    output logic              o_branch_taken,
    output logic              o_is_wait,
    output logic              o_is_halt
);

    always_comb begin
        o_pulse        = PULSE_NONE;
        o_data         = sext_imm(i_imm);
        o_branch_taken = 1'b0;
        o_is_wait      = 1'b0;
        o_is_halt      = 1'b0;
        case (i_opcode)
            OP_LOAD: o_pulse        = PULSE_LOAD;
            OP_INC:  o_pulse        = PULSE_INC;
            OP_DEC:  o_pulse        = PULSE_DEC;
            OP_BRZ:  o_branch_taken = i_zero;
            OP_BRP:  o_branch_taken = i_positive;
            OP_BRN:  o_branch_taken = i_negative;
            OP_JMP:  o_branch_taken = 1'b1;
            OP_WAIT: o_is_wait      = 1'b1;
            OP_HALT: o_is_halt      = 1'b1;
            default: o_pulse        = PULSE_NONE;
        endcase
    end

endmodule

// File: rtl/temp_sequencer.sv
// Four-cycle-slot micro-sequencer driving the temperature register's
// load/increment/decrement controls from a synchronous instruction ROM.
module temp_sequencer
    import temp_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               negative,
    input  logic               positive,
    input  logic               zero,
    output logic               load,
    output logic               increment,
    output logic               decrement,
    output logic [DATA_W-1:0]  data,
    output logic               busy,
    output logic               halted
);

    state_e              r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt;
    logic [IMM_W-1:0]    r_cnt, w_cnt_nxt;
    logic [PC_W-1:0]     r_target, w_target_nxt;
    logic                r_taken, w_taken_nxt;
    logic                r_is_wait, w_is_wait_nxt;
    logic                r_load, w_load_nxt;
    logic                r_inc, w_inc_nxt;
    logic                r_dec, w_dec_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_halted, w_halted_nxt;

    pulse_e              w_pulse;
    logic [DATA_W-1:0]   w_sext;
    logic                w_taken;
    logic                w_is_wait;
    logic                w_is_halt;
    logic [IMM_W-1:0]    w_imm;

    assign w_imm = rom_data[IMM_LSB +: IMM_W];

    temp_seq_decode u_decode (
        .i_opcode       (rom_data[OP_LSB +: OP_W]),
        .i_imm          (w_imm),
        .i_negative     (negative),
        .i_positive     (positive),
        .i_zero         (zero),
        .o_pulse        (w_pulse),
        .o_data         (w_sext),
        .o_branch_taken (w_taken),
        .o_is_wait      (w_is_wait),
        .o_is_halt      (w_is_halt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus next values of every registered output and slot register.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_target_nxt  = r_target;
        w_taken_nxt   = r_taken;
        w_is_wait_nxt = r_is_wait;
        w_load_nxt    = 1'b0;
        w_inc_nxt     = 1'b0;
        w_dec_nxt     = 1'b0;
        w_data_nxt    = r_data;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = '0;
                end
            end
            ST_FETCH: w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                w_state_nxt   = w_is_halt ? ST_HALT : ST_EXEC;
                w_taken_nxt   = w_taken;
                w_target_nxt  = PC_W'(w_imm);
                w_is_wait_nxt = w_is_wait;
                w_cnt_nxt     = w_imm;
                w_load_nxt    = (w_pulse == PULSE_LOAD);
                w_inc_nxt     = (w_pulse == PULSE_INC);
                w_dec_nxt     = (w_pulse == PULSE_DEC);
                if (w_pulse == PULSE_LOAD) w_data_nxt = w_sext;
            end
            ST_EXEC: begin
                w_state_nxt = r_is_wait ? ST_WAIT : ST_SETTLE;
                w_pc_nxt    = r_taken ? r_target : r_pc + PC_W'(1);
            end
            ST_WAIT: begin
                if (r_cnt == '0) w_state_nxt = ST_SETTLE;
                else             w_cnt_nxt   = r_cnt - IMM_W'(1);
            end
            ST_SETTLE: w_state_nxt = ST_FETCH;
            default:   w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt   = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HALT);
        w_halted_nxt = (w_state_nxt == ST_HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= '0;
            r_cnt     <= '0;
            r_target  <= '0;
            r_taken   <= 1'b0;
            r_is_wait <= 1'b0;
            r_load    <= 1'b0;
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_target  <= w_target_nxt;
            r_taken   <= w_taken_nxt;
            r_is_wait <= w_is_wait_nxt;
            r_load    <= w_load_nxt;
            r_inc     <= w_inc_nxt;
            r_dec     <= w_dec_nxt;
            r_data    <= w_data_nxt;
            r_busy    <= w_busy_nxt;
            r_halted  <= w_halted_nxt;
        end
    end

    assign rom_addr  = r_pc;
    assign load      = r_load;
    assign increment = r_inc;
    assign decrement = r_dec;
    assign data      = r_data;
    assign busy      = r_busy;
    assign halted    = r_halted;

endmodule
